instruction_fetch: RTL and testbench

- Consumer of the program counter value: reads the current PC and fetches the 32-bit instruction at that address over an 8-bit, active-low-request memory bus.
- Issues four byte reads, assembles them little-endian, then signals completion to the control sequencer, which then advances the PC register.
- Flags misaligned PCs and unresponsive memory as faults.

---
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads four bytes over an 8-bit active-low-request bus,
// assembles a little-endian 32-bit instruction and reports misalignment/timeout faults.
module instruction_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_n,
  input  logic [31:0] pc,
  output logic [31:0] mem_addr,
  output logic        mem_rd_n,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic [31:0] instr,
  output logic        done,
  output logic        busy,
  output logic        fault_misaligned,
  output logic        fault_timeout
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      base;
  logic [1:0]       idx;
  logic [CNT_W-1:0] wait_cnt;
  logic             start_ok;
  logic             misaligned;
  logic             last_wait;

  assign start_ok   = (state == IDLE) && !start_n;
  assign misaligned = (pc[1:0] != 2'b00);
  assign last_wait  = (wait_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: bus and handshake outputs are decoded purely from state, so an
  // asynchronous reset deasserts mem_rd_n immediately, without a clock edge.
  always_comb begin
    state_nxt = state;
    mem_rd_n  = 1'b1;
    mem_addr  = '0;
    done      = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok && !misaligned) state_nxt = REQ;
      end
      REQ: begin
        mem_rd_n = 1'b0;
        mem_addr = base + {30'd0, idx};
        busy     = 1'b1;
        if (mem_ack) begin
          if (idx == 2'd3) state_nxt = DONE;
        end else if (last_wait) begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base             <= '0;
      idx              <= '0;
      wait_cnt         <= '0;
      instr            <= '0;
      fault_misaligned <= 1'b0;
      fault_timeout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            instr            <= '0;
            fault_timeout    <= 1'b0;
            fault_misaligned <= misaligned;
            if (!misaligned) begin
              base     <= pc;
              idx      <= '0;
              wait_cnt <= '0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            // An ack on the last allowed cycle takes priority over the timeout.
            instr[{idx, 3'b000} +: 8] <= mem_data;
            wait_cnt                  <= '0;
            if (idx != 2'd3) idx <= idx + 2'd1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (last_wait) fault_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a byte-memory responder pops expected
// address/data beats, and a done monitor pops expected instructions from a scoreboard.
module tb_instruction_fetch;

  localparam int TO = 4;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_n = 1'b1;
  logic [31:0] pc      = '0;
  logic [7:0]  mem_data = '0;
  logic        mem_ack  = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rd_n;
  logic [31:0] instr;
  logic        done;
  logic        busy;
  logic        fault_misaligned;
  logic        fault_timeout;

  instruction_fetch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start_n          (start_n),
    .pc               (pc),
    .mem_addr         (mem_addr),
    .mem_rd_n         (mem_rd_n),
    .mem_data         (mem_data),
    .mem_ack          (mem_ack),
    .instr            (instr),
    .done             (done),
    .busy             (busy),
    .fault_misaligned (fault_misaligned),
    .fault_timeout    (fault_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory responder: acks only when it has a beat queued, after mem_wait idle cycles.
  int mem_wait = 0;
  int mem_wcnt = 0;
  bit spurious = 1'b0;

  always @(negedge clk) begin
    if (reset_n && !mem_rd_n && beat_q.size() != 0) begin
      if (mem_wcnt < mem_wait) begin
        mem_ack = 1'b0;
        mem_wcnt++;
      end else begin
        beat_t b;
        b = beat_q.pop_front();
        check("mem_addr", mem_addr, b.addr);
        mem_data = b.data;
        mem_ack  = 1'b1;
        mem_wcnt = 0;
      end
    end else begin
      if (mem_rd_n) mem_wcnt = 0;
      mem_ack  = spurious;
      mem_data = spurious ? 8'($urandom) : 8'h00;
    end
  end

  // Cycle counter and done monitor.
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rd_low   = 0;
  int s_cyc    = 0;
  bit prev_done = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!mem_rd_n) rd_low++;
    if (prev_done) begin
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("busy_after_done", {31'd0, busy}, 32'd0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_in_done", {31'd0, busy}, 32'd1);
      check("rd_n_in_done", {31'd0, mem_rd_n}, 32'd1);
      if (exp_q.size() == 0) check("unexpected_done", {31'd0, done}, 32'd0);
      else                   check("instr", instr, exp_q.pop_front());
    end
    prev_done = done;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.addr = a + 32'(i);
      b.data = w[8*i +: 8];
      beat_q.push_back(b);
    end
    exp_q.push_back(w);
  endtask

  task automatic do_start(input logic [31:0] p);
    pc      = p;
    start_n = 1'b0;
    s_cyc   = cyc;
    step();
    start_n = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check("done_seen", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_n"},  {31'd0, mem_rd_n}, 32'd1);
    check({tag, "_addr"},  mem_addr, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_faults"}, {30'd0, fault_misaligned, fault_timeout}, 32'd0);
  endtask

  initial begin
    int d0;

    #3;
    check_reset_outputs("reset");
    step();
    step();
    reset_n = 1'b1;
    step();

    // 1: ack every cycle, latency and byte order.
    mem_wait = 0;
    push_fetch(32'h100, 32'h0010_0513);
    rd_low = 0;
    do_start(32'h100);
    wait_done(20);
    check("t1_latency", 32'(done_cyc - s_cyc), 32'd5);
    check("t1_rd_low", 32'(rd_low), 32'd4);
    step();
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // 2: three wait cycles before each ack.
    mem_wait = 3;
    push_fetch(32'h200, 32'h5634_12B7);
    rd_low = 0;
    do_start(32'h200);
    wait_done(40);
    check("t2_rd_low", 32'(rd_low), 32'd16);
    check("t2_faults", {30'd0, fault_misaligned, fault_timeout}, 32'd0);
    step();

    // 3: misaligned start, then recovery.
    mem_wait = 0;
    d0 = done_cnt;
    rd_low = 0;
    do_start(32'h102);
    check("t3_misaligned", {31'd0, fault_misaligned}, 32'd1);
    check("t3_rd_n", {31'd0, mem_rd_n}, 32'd1);
    repeat (5) step();
    check("t3_no_done", 32'(done_cnt), 32'(d0));
    check("t3_no_bus", 32'(rd_low), 32'd0);
    check("t3_sticky", {31'd0, fault_misaligned}, 32'd1);
    push_fetch(32'h104, 32'hDEAD_BEEF);
    do_start(32'h104);
    check("t3_cleared", {31'd0, fault_misaligned}, 32'd0);
    wait_done(20);
    step();

    // 4a: memory never acks.
    d0 = done_cnt;
    rd_low = 0;
    do_start(32'h0);
    repeat (8) step();
    check("t4_rd_low", 32'(rd_low), 32'(TO));
    check("t4_timeout", {31'd0, fault_timeout}, 32'd1);
    check("t4_idle", {30'd0, busy, mem_rd_n}, 32'd1);
    check("t4_no_done", 32'(done_cnt), 32'(d0));

    // 4b: ack on the final allowed cycle wins.
    mem_wait = TO - 1;
    push_fetch(32'h8, 32'h4433_2211);
    rd_low = 0;
    do_start(32'h8);
    check("t4b_cleared", {31'd0, fault_timeout}, 32'd0);
    wait_done(40);
    check("t4b_no_fault", {30'd0, fault_misaligned, fault_timeout}, 32'd0);
    check("t4b_rd_low", 32'(rd_low), 32'(4 * TO));
    step();

    // 5: asynchronous reset in the middle of byte 2.
    mem_wait = 2;
    push_fetch(32'h20, 32'hDDCC_BBAA);
    do_start(32'h20);
    for (int i = 0; i < 30 && mem_addr != 32'h22; i++) step();
    check("t5_byte2", mem_addr, 32'h22);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    beat_q.delete();
    exp_q.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
    mem_wait = 0;
    push_fetch(32'h40, 32'h0000_8067);
    do_start(32'h40);
    wait_done(20);
    step();

    // 6: pc change, extra start and spurious acks are ignored.
    mem_wait = 1;
    d0 = done_cnt;
    push_fetch(32'h300, 32'h1234_5678);
    do_start(32'h300);
    step();
    pc       = 32'h500;
    start_n  = 1'b0;
    spurious = 1'b1;
    step();
    step();
    start_n = 1'b1;
    wait_done(40);
    repeat (6) step();
    check("t6_one_done", 32'(done_cnt), 32'(d0 + 1));
    check("t6_idle", {30'd0, busy, mem_rd_n}, 32'd1);
    check("t6_instr_hold", instr, 32'h1234_5678);
    spurious = 1'b0;
    step();

    check("beats_left", 32'(beat_q.size()), 32'd0);
    check("instr_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
